// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with a framed run: counts pattern matches over cfg_len accepted bits.
// Latency: z is combinational (Mealy) on the matching bit; match_cnt updates on that same edge.
// Flow: x_valid=0 stalls the frame in place; cfg_we and start are ignored while busy.
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             start,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Depth counts history bits gathered since the frame start or the last
    // non-overlapping match; a compare is only meaningful once it is full.
    localparam int              DW      = $clog2(PAT_W);
    localparam logic [DW-1:0]   FULL    = DW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [PAT_W-1:0] pat_r;
    logic             ovl_r;
    logic [CNT_W-1:0] len_r;
    logic [PAT_W-2:0] hist;
    logic [DW-1:0]    depth;
    logic [CNT_W-1:0] bit_cnt;

    logic             accept;
    logic [PAT_W-1:0] window;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic [CNT_W-1:0] start_len;

    assign accept      = (state == RUN) && x_valid;
    assign window      = {hist, x};
    assign bit_cnt_nxt = bit_cnt + CNT_W'(1);
    // A write coinciding with start must already govern that frame.
    assign start_len   = cfg_we ? cfg_len : len_r;

    assign z    = accept && (depth == FULL) && (window == pat_r);
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Configuration is only writable while idle so a frame sees one fixed setup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r <= '0;
            ovl_r <= 1'b1;
            len_r <= '0;
        end else if ((state == IDLE) && cfg_we) begin
            pat_r <= cfg_pattern;
            ovl_r <= cfg_overlap;
            len_r <= cfg_len;
        end
    end

    // Frame sequencing: IDLE -> RUN (or straight to DONE for an empty frame) -> DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= (start_len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (x_valid && (bit_cnt_nxt == len_r)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bit history, fill depth and counters; a match either keeps the window
    // primed (overlap) or discards the matched bits (non-overlap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            depth     <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            hist      <= '0;
            depth     <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
        end else if (accept) begin
            hist    <= window[PAT_W-2:0];
            bit_cnt <= bit_cnt_nxt;
            if (z) begin
                if (match_cnt != CNT_MAX) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
                depth <= ovl_r ? FULL : '0;
            end else if (depth != FULL) begin
                depth <= depth + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: overlap, non-overlap, stall, empty frame,
// ignored mid-frame writes and mid-frame reset, each against hand-computed results.
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next one.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic [7:0] cfg_len;
    logic       start;
    logic       x;
    logic       x_valid;
    logic       z;
    logic       busy;
    logic       done;
    logic [7:0] match_cnt;

    int checks = 0;
    int errors = 0;

    // Stream 1010101001010, bit index 0 is the MSB of the vector.
    logic [12:0] stream = 13'b1010101001010;
    // Expected z per bit index (index 0 = MSB): overlap hits 4,6,11; non-overlap 4,11.
    logic [12:0] z_ovl  = 13'b0000101000010;
    logic [12:0] z_nov  = 13'b0000100000010;

    seq_detect_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cfg_len     (cfg_len),
        .start       (start),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .busy        (busy),
        .done        (done),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic ez, input string tag, input int idx);
        x       = b;
        x_valid = 1'b1;
        #1;
        chk($sformatf("%s:z[%0d]", tag, idx), 32'(z), 32'(ez));
        chk($sformatf("%s:done_early[%0d]", tag, idx), 32'(done), 32'd0);
        tick();
        x_valid = 1'b0;
    endtask

    // Stall with a bit that would complete a match if it were taken.
    task automatic stall_cycle(input string tag);
        x       = 1'b1;
        x_valid = 1'b0;
        #1;
        chk({tag, ":z_stall"}, 32'(z), 32'd0);
        chk({tag, ":busy_stall"}, 32'(busy), 32'd1);
        tick();
    endtask

    task automatic run_frame(input logic ovl, input logic do_cfg, input int stall_at,
                             input int inj_at, input logic [12:0] zmask,
                             input int exp_cnt, input string tag);
        cfg_we      = do_cfg;
        cfg_pattern = 4'b0101;
        cfg_overlap = ovl;
        cfg_len     = 8'd13;
        start       = 1'b1;
        x_valid     = 1'b0;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        chk({tag, ":busy_go"}, 32'(busy), 32'd1);
        chk({tag, ":cnt_clr"}, 32'(match_cnt), 32'd0);
        for (int i = 0; i < 13; i++) begin
            if (i == inj_at) begin
                cfg_we      = 1'b1;
                cfg_pattern = 4'b1111;
                cfg_len     = 8'd5;
                cfg_overlap = ~ovl;
                start       = 1'b1;
            end
            send_bit(stream[12-i], zmask[12-i], tag, i);
            cfg_we = 1'b0;
            start  = 1'b0;
            if (i == stall_at) begin
                for (int k = 0; k < 3; k++) stall_cycle(tag);
            end
        end
        // In DONE the history is 010 with a full window: x=1 would match if z leaked.
        x       = 1'b1;
        x_valid = 1'b1;
        #1;
        chk({tag, ":done"}, 32'(done), 32'd1);
        chk({tag, ":busy_done"}, 32'(busy), 32'd1);
        chk({tag, ":z_in_done"}, 32'(z), 32'd0);
        chk({tag, ":match_cnt"}, 32'(match_cnt), 32'(exp_cnt));
        tick();
        x_valid = 1'b0;
        chk({tag, ":done_clr"}, 32'(done), 32'd0);
        chk({tag, ":busy_idle"}, 32'(busy), 32'd0);
        chk({tag, ":cnt_hold"}, 32'(match_cnt), 32'(exp_cnt));
    endtask

    initial begin
        rst         = 1'b1;
        cfg_we      = 1'b0;
        cfg_pattern = 4'b0000;
        cfg_overlap = 1'b0;
        cfg_len     = 8'd0;
        start       = 1'b0;
        x           = 1'b0;
        x_valid     = 1'b1;
        #12;
        // Reset state: pattern 0 with x=0 must not produce z outside RUN.
        chk("rst:z", 32'(z), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:match_cnt", 32'(match_cnt), 32'd0);
        x_valid = 1'b0;
        rst     = 1'b0;

        // Reset length is 0: the first start goes straight to DONE on the first edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_len0:done", 32'(done), 32'd1);
        chk("rst_len0:busy", 32'(busy), 32'd1);
        tick();
        chk("rst_len0:done_clr", 32'(done), 32'd0);
        chk("rst_len0:busy_clr", 32'(busy), 32'd0);

        run_frame(1'b1, 1'b1, -1, -1, z_ovl, 3, "ovl");
        run_frame(1'b0, 1'b1, -1, -1, z_nov, 2, "nov");
        run_frame(1'b1, 1'b1,  5, -1, z_ovl, 3, "stall");

        // Empty frame written together with start; must clear the previous count.
        cfg_we      = 1'b1;
        cfg_pattern = 4'b0101;
        cfg_overlap = 1'b1;
        cfg_len     = 8'd0;
        start       = 1'b1;
        tick();
        cfg_we  = 1'b0;
        start   = 1'b0;
        x       = 1'b1;
        x_valid = 1'b1;
        #1;
        chk("len0:done", 32'(done), 32'd1);
        chk("len0:z", 32'(z), 32'd0);
        chk("len0:match_cnt", 32'(match_cnt), 32'd0);
        tick();
        x_valid = 1'b0;
        chk("len0:done_clr", 32'(done), 32'd0);
        chk("len0:busy_clr", 32'(busy), 32'd0);

        // Write of 1111/len 5/flipped mode plus start during RUN must be ignored.
        run_frame(1'b1, 1'b1, -1, 2, z_ovl, 3, "inj");
        // Following frame without a write still runs on 0101, overlap, length 13.
        run_frame(1'b1, 1'b0, -1, -1, z_ovl, 3, "inj_after");

        // Reset mid-frame at bit 7 of the overlap stream.
        cfg_we      = 1'b1;
        cfg_pattern = 4'b0101;
        cfg_overlap = 1'b1;
        cfg_len     = 8'd13;
        start       = 1'b1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(stream[12-i], z_ovl[12-i], "mid", i);
        chk("mid:cnt_before", 32'(match_cnt), 32'd2);
        x       = stream[5];
        x_valid = 1'b1;
        rst     = 1'b1;
        #1;
        chk("mid:z", 32'(z), 32'd0);
        chk("mid:busy", 32'(busy), 32'd0);
        chk("mid:done", 32'(done), 32'd0);
        chk("mid:match_cnt", 32'(match_cnt), 32'd0);
        tick();
        chk("mid:busy_held", 32'(busy), 32'd0);
        x_valid = 1'b0;
        rst     = 1'b0;
        #2;
        run_frame(1'b1, 1'b1, -1, -1, z_ovl, 3, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the stimulus stalls on a clock that never arrives.
    initial begin
        #20000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter PAT_W, default 4, SHALL set the pattern length in bits; the legal range is 2..8.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the frame-length and match counters.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 cfg_we  input  1  SHALL be the configuration write strobe.
REQ-006 cfg_pattern  input  PAT_W  SHALL be the target pattern; the MSB is the first bit received.
REQ-007 cfg_overlap  input  1  SHALL select the mode: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-008 cfg_len  input  CNT_W  SHALL be the frame length, in accepted bits.
REQ-009 start  input  1  SHALL be a one-cycle request to begin a frame.
REQ-010 x  input  1  SHALL be the serial data bit.
REQ-011 x_valid  input  1  SHALL qualify x; a bit is accepted only when x_valid=1.
REQ-012 z  output  1  SHALL be the Mealy match pulse.
REQ-013 busy  output  1  SHALL indicate a frame in progress.
REQ-014 done  output  1  SHALL be the one-cycle end-of-frame pulse.
REQ-015 match_cnt  output  CNT_W  SHALL hold the number of matches in the current or last frame.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE, cfg_we=1 SHALL register cfg_pattern, cfg_overlap and cfg_len.
REQ-018 cfg_we SHALL be ignored in RUN and DONE; the active configuration SHALL stay fixed for the whole frame.
REQ-019 IDLE with start=1 and a registered length != 0 SHALL:
  - go to RUN on the next edge;
  - clear match_cnt, the bit counter, the history register and the fill depth.
REQ-020 IDLE with start=1 and a registered length == 0 SHALL:
  - go directly to DONE;
  - set match_cnt to 0.
REQ-021 If cfg_we and start are both 1 in IDLE, the frame SHALL use the newly written configuration.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 In RUN, each accepted bit SHALL:
  - shift into the (PAT_W-1)-bit history, MSB-first order;
  - increment the bit counter;
  - increment the fill depth, saturating at PAT_W-1.
REQ-024 z SHALL be combinational and equal 1 exactly when all of these hold:
  - state = RUN;
  - x_valid = 1;
  - fill depth = PAT_W-1;
  - {history, x} == registered pattern.
REQ-025 z SHALL be 0 in all other cases, including IDLE, DONE and cycles with x_valid=0.
REQ-026 When z=1, match_cnt SHALL increment on the same edge, saturating at 2^CNT_W-1.
REQ-027 When z=1 and the mode is overlapping, the fill depth SHALL stay at PAT_W-1.
REQ-028 When z=1 and the mode is non-overlapping, the fill depth SHALL reset to 0; the matched bits SHALL NOT contribute to a later match.
REQ-029 Cycles with x_valid=0 in RUN SHALL hold the history, depth, counters and state unchanged.
REQ-030 RUN SHALL go to DONE on the edge that accepts bit number cfg_len; a z on that final bit SHALL still be counted.
REQ-031 DONE SHALL last exactly one cycle, with done=1, and SHALL then go to IDLE.
REQ-032 busy SHALL be 1 whenever the state is not IDLE.
REQ-033 match_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-034 While rst=1, the following SHALL hold, at any time including mid-frame:
  - state = IDLE;
  - z = 0, busy = 0, done = 0, match_cnt = 0;
  - history, depth and bit counter = 0;
  - pattern = 0, overlap = 1, length = 0.
REQ-035 The first start SHALL be honoured on the first clock edge after rst deasserts.

Verification
REQ-036 Overlap scenario: pattern 0101, overlap=1, len=13, stream 1010101001010 with x_valid held 1 -> z=1 on bit indices 4, 6 and 11 (0-based); done pulses on bit 12; match_cnt=3.
REQ-037 Non-overlap scenario: the same stream with overlap=0 -> z=1 on indices 4 and 11 only; match_cnt=2.
REQ-038 Stall scenario: the overlap stream with x_valid=0 inserted for 3 cycles after bit 5 -> the same z sequence by accepted bit; done arrives 3 cycles later.
REQ-039 Zero-length scenario: len=0, then start -> DONE on the next cycle, done=1 for 1 cycle, match_cnt=0, no z.
REQ-040 Reset mid-frame: assert rst at bit 7 of the overlap stream -> outputs clear immediately; a restart after release yields match_cnt=3.
REQ-041 Ignored-write scenario: cfg_we with pattern 1111 and start=1 during RUN -> the frame completes using 0101; the new pattern is NOT applied.
